// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo_if
// Description : Byte-stream bus between the UART receiver/host and the RX FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_if #(
    parameter int DBIT   = 8,
    parameter int ADDR_W = 4
);
    logic            wr;
    logic [DBIT-1:0] w_data;
    logic            rd;
    logic            clr_overrun;
    logic [DBIT-1:0] r_data;
    logic            empty;
    logic            full;
    logic            almost_full;
    logic [ADDR_W:0] count;
    logic            overrun;

    modport master (
        output wr, w_data, rd, clr_overrun,
        input  r_data, empty, full, almost_full, count, overrun
    );

    modport slave (
        input  wr, w_data, rd, clr_overrun,
        output r_data, empty, full, almost_full, count, overrun
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : FWFT circular receive buffer with occupancy and sticky overrun.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DBIT     = 8,
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 12
) (
    input  wire logic     clk,
    input  wire logic     reset,
    uart_rx_fifo_if.slave bus
);
    localparam int              c_DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] c_AF_LEVEL = (ADDR_W + 1)'(AF_LEVEL);

    logic [DBIT-1:0] r_mem [c_DEPTH];
    logic [ADDR_W:0] r_wr_ptr;
    logic [ADDR_W:0] r_rd_ptr;
    logic            r_overrun;

    logic            w_empty;
    logic            w_full;
    logic [ADDR_W:0] w_count;
    logic            w_do_wr;
    logic            w_do_rd;
    logic            w_drop;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                     (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);
    assign w_count = r_wr_ptr - r_rd_ptr;

    // A simultaneous pop frees the slot, so a write while full still lands.
    assign w_do_rd = bus.rd && !w_empty;
    assign w_do_wr = bus.wr && (!w_full || bus.rd);
    assign w_drop  = bus.wr && w_full && !bus.rd;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_overrun <= 1'b0;
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_wr) begin
                r_mem[r_wr_ptr[ADDR_W-1:0]] <= bus.w_data;
                r_wr_ptr                    <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // Set has priority over clear so a drop is never hidden.
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (bus.clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign bus.r_data      = r_mem[r_rd_ptr[ADDR_W-1:0]];
    assign bus.empty       = w_empty;
    assign bus.full        = w_full;
    assign bus.count       = w_count;
    assign bus.almost_full = (w_count >= c_AF_LEVEL);
    assign bus.overrun     = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Directed self-checking bench for uart_rx_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    uart_rx_fifo_if #(.DBIT(8), .ADDR_W(4)) bus ();

    uart_rx_fifo #(.DBIT(8), .ADDR_W(4), .AF_LEVEL(12)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr          = 1'b0;
        bus.rd          = 1'b0;
        bus.clr_overrun = 1'b0;
        bus.w_data      = 8'h00;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        step();
        step();
        reset = 1'b0;
        checks++;
        if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.almost_full !== 1'b0 ||
            bus.count !== 5'd0 || bus.overrun !== 1'b0 || bus.r_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_state got e=%b f=%b af=%b cnt=%0d ov=%b rd=%h exp e=1 f=0 af=0 cnt=0 ov=0 rd=00",
                     bus.empty, bus.full, bus.almost_full, bus.count, bus.overrun, bus.r_data);
        end
    endtask

    task automatic test_single();
        bus.wr = 1'b1; bus.w_data = 8'h55;
        step();
        idle();
        checks++;
        if (bus.empty !== 1'b0 || bus.count !== 5'd1 || bus.r_data !== 8'h55) begin
            errors++;
            $display("FAIL single_write got e=%b cnt=%0d rd=%h exp e=0 cnt=1 rd=55",
                     bus.empty, bus.count, bus.r_data);
        end
        bus.rd = 1'b1;
        step();
        idle();
        checks++;
        if (bus.empty !== 1'b1 || bus.count !== 5'd0) begin
            errors++;
            $display("FAIL single_pop got e=%b cnt=%0d exp e=1 cnt=0", bus.empty, bus.count);
        end
    endtask

    task automatic fill_16();
        for (int k = 1; k <= 16; k++) begin
            bus.wr = 1'b1; bus.w_data = 8'(k);
            step();
            idle();
            checks++;
            if (bus.count !== 5'(k) || bus.almost_full !== (k >= 12) || bus.full !== (k == 16)) begin
                errors++;
                $display("FAIL fill_%0d got cnt=%0d af=%b f=%b exp cnt=%0d af=%b f=%b",
                         k, bus.count, bus.almost_full, bus.full, k, (k >= 12), (k == 16));
            end
        end
    endtask

    task automatic test_fill_drain();
        fill_16();
        for (int k = 1; k <= 16; k++) begin
            checks++;
            if (bus.r_data !== 8'(k)) begin
                errors++;
                $display("FAIL drain_%0d got %h exp %h", k, bus.r_data, 8'(k));
            end
            bus.rd = 1'b1;
            step();
            idle();
        end
        checks++;
        if (bus.empty !== 1'b1 || bus.count !== 5'd0) begin
            errors++;
            $display("FAIL drain_empty got e=%b cnt=%0d exp e=1 cnt=0", bus.empty, bus.count);
        end
    endtask

    task automatic test_overrun();
        fill_16();
        bus.wr = 1'b1; bus.w_data = 8'hAA;
        step();
        idle();
        checks++;
        if (bus.overrun !== 1'b1 || bus.count !== 5'd16) begin
            errors++;
            $display("FAIL overrun_set got ov=%b cnt=%0d exp ov=1 cnt=16", bus.overrun, bus.count);
        end
        bus.wr = 1'b1; bus.w_data = 8'hAA; bus.clr_overrun = 1'b1;
        step();
        idle();
        checks++;
        if (bus.overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set_wins got %b exp 1", bus.overrun);
        end
        bus.clr_overrun = 1'b1;
        step();
        idle();
        checks++;
        if (bus.overrun !== 1'b0 || bus.count !== 5'd16) begin
            errors++;
            $display("FAIL overrun_clear got ov=%b cnt=%0d exp ov=0 cnt=16", bus.overrun, bus.count);
        end
    endtask

    // Starts from the full FIFO left by test_overrun (01..10, no 0xAA).
    task automatic test_full_simul();
        logic [7:0] exp_seq [16];
        for (int k = 0; k < 15; k++) exp_seq[k] = 8'(k + 2);
        exp_seq[15] = 8'hBB;
        bus.wr = 1'b1; bus.w_data = 8'hBB; bus.rd = 1'b1;
        step();
        idle();
        checks++;
        if (bus.count !== 5'd16 || bus.overrun !== 1'b0 || bus.full !== 1'b1) begin
            errors++;
            $display("FAIL full_simul got cnt=%0d ov=%b f=%b exp cnt=16 ov=0 f=1",
                     bus.count, bus.overrun, bus.full);
        end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (bus.r_data !== exp_seq[k]) begin
                errors++;
                $display("FAIL full_simul_rd%0d got %h exp %h", k, bus.r_data, exp_seq[k]);
            end
            bus.rd = 1'b1;
            step();
            idle();
        end
        checks++;
        if (bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL full_simul_empty got %b exp 1", bus.empty);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] q [$];
        logic [7:0] b;
        int         nwr;
        int         maxcnt;
        nwr    = 0;
        maxcnt = 0;
        for (int cyc = 0; cyc < 43; cyc++) begin
            idle();
            if (nwr < 40) begin
                b = 8'((nwr * 37 + 11) & 8'hFF);
                bus.wr = 1'b1; bus.w_data = b;
            end
            if (q.size() == 3 || (nwr >= 40 && q.size() > 0)) begin
                checks++;
                if (bus.r_data !== q[0]) begin
                    errors++;
                    $display("FAIL wrap_data_c%0d got %h exp %h", cyc, bus.r_data, q[0]);
                end
                bus.rd = 1'b1;
                void'(q.pop_front());
            end
            if (bus.wr) begin
                q.push_back(b);
                nwr++;
            end
            step();
            if (int'(bus.count) > maxcnt) maxcnt = int'(bus.count);
        end
        idle();
        checks++;
        if (maxcnt != 3 || bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL wrap_count got max=%0d e=%b exp max=3 e=1", maxcnt, bus.empty);
        end
        bus.rd = 1'b1;
        step();
        idle();
        checks++;
        if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin
            errors++;
            $display("FAIL rd_on_empty got cnt=%0d e=%b f=%b exp cnt=0 e=1 f=0",
                     bus.count, bus.empty, bus.full);
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 5; k++) begin
            bus.wr = 1'b1; bus.w_data = 8'(8'hC0 + k);
            step();
        end
        idle();
        checks++;
        if (bus.count !== 5'd5) begin
            errors++;
            $display("FAIL reset_mid_load got %0d exp 5", bus.count);
        end
        reset = 1'b1;
        bus.wr = 1'b1; bus.rd = 1'b1; bus.w_data = 8'h77;
        step();
        reset = 1'b0;
        idle();
        checks++;
        if (bus.empty !== 1'b1 || bus.count !== 5'd0 || bus.r_data !== 8'h00 ||
            bus.overrun !== 1'b0 || bus.full !== 1'b0 || bus.almost_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got e=%b cnt=%0d rd=%h ov=%b f=%b af=%b exp e=1 cnt=0 rd=00 ov=0 f=0 af=0",
                     bus.empty, bus.count, bus.r_data, bus.overrun, bus.full, bus.almost_full);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        idle();
        #1;
        test_reset();
        test_single();
        test_fill_drain();
        test_overrun();
        test_full_simul();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
